// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg
// Shared definitions for the round-robin arbiter that drives the select
// lines of the 4:1 single-bit mux (mux_3_1).
//   N_REQ  : number of requesters (one per mux input i0..i3)
//   IDX_W  : width of a requester index / mux select
//   CNT_W  : width of the burst counter
//   arb_state_t : IDLE / GRANT
//   idx2onehot  : requester index to one-hot grant vector
package mux_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational rotating-priority finder. Scans (req & mask) starting at
// position ptr, wrapping 3 -> 0, and reports the first set bit.
// Ports:
//   req   [3:0] in  : raw request vector
//   ptr   [1:0] in  : scan start position (highest priority)
//   mask  [3:0] in  : 1 = candidate allowed
//   found       out : at least one masked request is set
//   idx   [1:0] out : index of the first masked request from ptr
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] w_cand;
  logic [IDX_W-1:0] w_pos;

  assign w_cand = req & mask;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    w_pos = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      // Truncation to IDX_W bits gives the 3 -> 0 wrap for free.
      w_pos = IDX_W'(32'(ptr) + k);
      if (!found && w_cand[w_pos]) begin
        found = 1'b1;
        idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter in front of the 4:1 mux (mux_3_1). Grants one
// requester at a time and drives the mux selects from registered state so
// the mux output y carries the granted requester's input.
// Parameters:
//   BURST_MAX (1..15) : max consecutive grant cycles before forced rotation
//                       when others are pending (only with burst limit)
// Ports:
//   clk        in  : clock, rising edge
//   rst        in  : synchronous active-high reset
//   req  [3:0] in  : request per requester, req[k] <-> mux input ik
//   gnt  [3:0] out : one-hot grant, all zero when idle
//   sel0       out : mux select MSB
//   sel1       out : mux select LSB ({sel0,sel1} = granted index)
//   valid      out : a grant is active, y is meaningful
// Build option:
//   MUX_ARB_BURST_LIMIT_EN : enables burst-limit preemption. Undefined, the
//                            owner keeps the grant until it drops req.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       sel0,
  output logic       sel1,
  output logic       valid
);

  if (BURST_MAX == 0 || BURST_MAX > 15) begin : g_bad_burst_max
    $error("mux_rr_arbiter: BURST_MAX must be in 1..15");
  end

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_ptr;
`ifdef MUX_ARB_BURST_LIMIT_EN
  logic [CNT_W-1:0] r_cnt;
`endif

  logic [N_REQ-1:0] w_mask;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  // The pointer always equals owner+1 while granting, so a single picker
  // started at r_ptr serves both the idle pick and the handoff pick; in
  // GRANT the current owner is masked out so it is never re-picked.
  assign w_mask = (r_state == GRANT) ? ~idx2onehot(r_owner) : '1;

  rr_pick u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .mask  (w_mask),
    .found (w_found),
    .idx   (w_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      gnt     <= '0;
      sel0    <= 1'b0;
      sel1    <= 1'b0;
      valid   <= 1'b0;
`ifdef MUX_ARB_BURST_LIMIT_EN
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state      <= GRANT;
            r_owner      <= w_idx;
            r_ptr        <= w_idx + IDX_W'(1);
            gnt          <= idx2onehot(w_idx);
            {sel0, sel1} <= w_idx;
            valid        <= 1'b1;
`ifdef MUX_ARB_BURST_LIMIT_EN
            r_cnt        <= '0;
`endif
          end
        end

        GRANT: begin
          if (!req[r_owner]) begin
            if (w_found) begin
              // Direct handoff, no idle bubble.
              r_owner      <= w_idx;
              r_ptr        <= w_idx + IDX_W'(1);
              gnt          <= idx2onehot(w_idx);
              {sel0, sel1} <= w_idx;
              valid        <= 1'b1;
`ifdef MUX_ARB_BURST_LIMIT_EN
              r_cnt        <= '0;
`endif
            end else begin
              // sel keeps its last value while idle.
              r_state <= IDLE;
              gnt     <= '0;
              valid   <= 1'b0;
            end
          end else begin
`ifdef MUX_ARB_BURST_LIMIT_EN
            if (r_cnt == CNT_W'(BURST_MAX - 1)) begin
              if (w_found) begin
                r_owner      <= w_idx;
                r_ptr        <= w_idx + IDX_W'(1);
                gnt          <= idx2onehot(w_idx);
                {sel0, sel1} <= w_idx;
                valid        <= 1'b1;
              end
              // Either way a fresh burst starts; the counter never passes
              // BURST_MAX-1.
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
`endif
          end
        end

        default: begin
          r_state <= IDLE;
          gnt     <= '0;
          valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule
